// File: rtl/imm_encode_unit.sv
// Immediate encoder: packs a signed immediate into the I/S/J/B fields of a base
// instruction word, flags unrepresentable values, and queues results in a 2-entry FIFO.
module imm_encode_unit (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_val,
    output logic        in_rdy,
    input  logic [31:0] in_base,
    input  logic [31:0] in_imm,
    input  logic [1:0]  in_imm_type,
    output logic        out_val,
    input  logic        out_rdy,
    output logic [31:0] out_inst,
    output logic        out_err,
    output logic [7:0]  err_count
);

    typedef enum logic [1:0] {
        IMM_I = 2'd0,
        IMM_S = 2'd1,
        IMM_J = 2'd2,
        IMM_B = 2'd3
    } imm_type_t;

    imm_type_t   imm_type;
    logic [31:0] keep_mask;
    logic [31:0] ins_bits;
    logic        range_ok;
    logic        enc_err;
    logic [31:0] enc_inst;

    logic [31:0] mem_inst [2];
    logic        mem_err  [2];
    logic        wr_ptr;
    logic        rd_ptr;
    logic [1:0]  count;
    logic        enq;
    logic        deq;

    assign imm_type = imm_type_t'(in_imm_type);

    always_comb begin
        keep_mask = '1;
        ins_bits  = '0;
        range_ok  = 1'b1;
        case (imm_type)
            IMM_I: begin
                keep_mask = 32'h000F_FFFF;
                ins_bits  = {in_imm[11:0], 20'b0};
                range_ok  = (&in_imm[31:11]) || !(|in_imm[31:11]);
            end
            IMM_S: begin
                keep_mask = 32'h01FF_F07F;
                ins_bits  = {in_imm[11:5], 13'b0, in_imm[4:0], 7'b0};
                range_ok  = (&in_imm[31:11]) || !(|in_imm[31:11]);
            end
            IMM_J: begin
                keep_mask = 32'h0000_0FFF;
                ins_bits  = {in_imm[20], in_imm[10:1], in_imm[11], in_imm[19:12], 12'b0};
                range_ok  = ((&in_imm[31:20]) || !(|in_imm[31:20])) && !in_imm[0];
            end
            IMM_B: begin
                keep_mask = 32'h01FF_F07F;
                ins_bits  = {in_imm[12], in_imm[10:5], 13'b0, in_imm[4:1], in_imm[11], 7'b0};
                range_ok  = ((&in_imm[31:12]) || !(|in_imm[31:12])) && !in_imm[0];
            end
            default: begin
                keep_mask = '1;
                ins_bits  = '0;
                range_ok  = 1'b1;
            end
        endcase
        enc_err  = !range_ok;
        // An errored request still clears the immediate fields, it just inserts nothing.
        enc_inst = enc_err ? (in_base & keep_mask) : ((in_base & keep_mask) | ins_bits);
    end

    assign in_rdy   = (count != 2'd2);
    assign out_val  = (count != 2'd0);
    assign enq      = in_val && in_rdy;
    assign deq      = out_val && out_rdy;
    assign out_inst = mem_inst[rd_ptr];
    assign out_err  = mem_err[rd_ptr];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mem_inst[0] <= '0;
            mem_inst[1] <= '0;
            mem_err[0]  <= 1'b0;
            mem_err[1]  <= 1'b0;
            wr_ptr      <= 1'b0;
            rd_ptr      <= 1'b0;
            count       <= '0;
            err_count   <= '0;
        end else begin
            if (enq) begin
                mem_inst[wr_ptr] <= enc_inst;
                mem_err[wr_ptr]  <= enc_err;
                wr_ptr           <= ~wr_ptr;
                if (enc_err && (err_count != 8'hFF))
                    err_count <= err_count + 8'd1;
            end
            if (deq)
                rd_ptr <= ~rd_ptr;
            if (enq && !deq)
                count <= count + 2'd1;
            else if (deq && !enq)
                count <= count - 2'd1;
        end
    end

endmodule

// File: tb/tb_imm_encode_unit.sv
// Directed self-checking bench for imm_encode_unit: encodes, field clearing,
// range errors, backpressure, streaming, error-count saturation and async reset.
module tb_imm_encode_unit;

    logic        clk;
    logic        reset;
    logic        in_val;
    logic        in_rdy;
    logic [31:0] in_base;
    logic [31:0] in_imm;
    logic [1:0]  in_imm_type;
    logic        out_val;
    logic        out_rdy;
    logic [31:0] out_inst;
    logic        out_err;
    logic [7:0]  err_count;

    int n_checks = 0;
    int n_fail   = 0;

    imm_encode_unit dut (
        .clk         (clk),
        .reset       (reset),
        .in_val      (in_val),
        .in_rdy      (in_rdy),
        .in_base     (in_base),
        .in_imm      (in_imm),
        .in_imm_type (in_imm_type),
        .out_val     (out_val),
        .out_rdy     (out_rdy),
        .out_inst    (out_inst),
        .out_err     (out_err),
        .err_count   (err_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic [31:0] base, input logic [31:0] imm, input logic [1:0] typ);
        in_val      = 1'b1;
        in_base     = base;
        in_imm      = imm;
        in_imm_type = typ;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One request with out_rdy=1; result must be at the head one cycle after acceptance.
    task automatic send_one(input string tag, input logic [31:0] base, input logic [31:0] imm,
                            input logic [1:0] typ, input logic [31:0] exp_inst, input logic exp_err);
        drive(base, imm, typ);
        tick();
        in_val = 1'b0;
        check({tag, "_val"}, {31'b0, out_val}, 32'd1);
        check({tag, "_inst"}, out_inst, exp_inst);
        check({tag, "_err"}, {31'b0, out_err}, {31'b0, exp_err});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset = 1'b1; in_val = 1'b0; in_base = '0; in_imm = '0; in_imm_type = '0; out_rdy = 1'b1;
        tick(); tick();
        check("rst_out_val", {31'b0, out_val}, 32'd0);
        check("rst_in_rdy", {31'b0, in_rdy}, 32'd1);
        check("rst_err_count", {24'b0, err_count}, 32'd0);
        check("rst_out_inst", out_inst, 32'd0);
        reset = 1'b0;

        send_one("enc_i", 32'h0000_0013, 32'd5,         2'd0, 32'h0050_0013, 1'b0);
        send_one("enc_s", 32'h0000_2023, 32'hFFFF_FFFC, 2'd1, 32'hFE00_2E23, 1'b0);
        send_one("enc_j", 32'h0000_006F, 32'h0000_0800, 2'd2, 32'h0010_006F, 1'b0);
        send_one("enc_b", 32'h0000_0063, 32'hFFFF_F000, 2'd3, 32'h8000_0063, 1'b0);
        send_one("clr_i", 32'hFFFF_FFFF, 32'd0,         2'd0, 32'h000F_FFFF, 1'b0);
        send_one("clr_b", 32'hFFFF_FFFF, 32'd0,         2'd3, 32'h01FF_F07F, 1'b0);
        tick();
        check("drained", {31'b0, out_val}, 32'd0);
        check("err_count_0", {24'b0, err_count}, 32'd0);

        send_one("err_i", 32'h0000_0013, 32'h0000_0800, 2'd0, 32'h0000_0013, 1'b1);
        send_one("err_b", 32'h0000_0063, 32'd3,         2'd3, 32'h0000_0063, 1'b1);
        send_one("err_j", 32'h0000_006F, 32'h0010_0000, 2'd2, 32'h0000_006F, 1'b1);
        check("err_count_3", {24'b0, err_count}, 32'd3);
        tick();

        // Backpressure: two accepted, third held off until the queue drains.
        out_rdy = 1'b0;
        drive(32'h0000_0013, 32'd1, 2'd0);
        tick();
        check("bp_rdy1", {31'b0, in_rdy}, 32'd1);
        drive(32'h0000_0013, 32'd2, 2'd0);
        tick();
        check("bp_rdy_full", {31'b0, in_rdy}, 32'd0);
        drive(32'h0000_0013, 32'd3, 2'd0);
        for (int c = 0; c < 3; c++) begin
            tick();
            check("bp_stall_inst", out_inst, 32'h0010_0013);
            check("bp_stall_rdy", {31'b0, in_rdy}, 32'd0);
            check("bp_stall_val", {31'b0, out_val}, 32'd1);
        end
        out_rdy = 1'b1;
        tick();
        check("bp_second", out_inst, 32'h0020_0013);
        check("bp_rdy_again", {31'b0, in_rdy}, 32'd1);
        tick();
        in_val = 1'b0;
        check("bp_third", out_inst, 32'h0030_0013);
        tick();
        check("bp_empty", {31'b0, out_val}, 32'd0);

        // Streaming at count 1: enqueue and dequeue every cycle.
        for (int i = 0; i < 10; i++) begin
            drive(32'h0000_0013, i + 32'd16, 2'd0);
            tick();
            check("stream_inst", out_inst, ((i + 32'd16) << 20) | 32'h13);
            check("stream_rdy", {31'b0, in_rdy}, 32'd1);
        end
        in_val = 1'b0;
        tick();
        check("stream_empty", {31'b0, out_val}, 32'd0);

        // Saturation: 300 errored requests back to back.
        drive(32'h0000_0013, 32'h0000_0800, 2'd0);
        for (int i = 0; i < 300; i++) tick();
        in_val = 1'b0;
        check("sat_count", {24'b0, err_count}, 32'd255);
        tick();

        // Async reset with two entries queued.
        out_rdy = 1'b0;
        drive(32'h0000_0013, 32'd7, 2'd0);
        tick();
        drive(32'h0000_0013, 32'd8, 2'd0);
        tick();
        in_val = 1'b0;
        check("pre_rst_full", {31'b0, in_rdy}, 32'd0);
        #2;
        reset = 1'b1;
        #1;
        check("async_out_val", {31'b0, out_val}, 32'd0);
        check("async_in_rdy", {31'b0, in_rdy}, 32'd1);
        check("async_err_count", {24'b0, err_count}, 32'd0);
        tick();
        reset = 1'b0;
        out_rdy = 1'b1;
        send_one("post_rst", 32'h0000_0013, 32'd9, 2'd0, 32'h0090_0013, 1'b0);
        tick();
        check("post_rst_empty", {31'b0, out_val}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/imm_encode_unit.md
# imm_encode_unit

Immediate encoder for the TinyRV1 toolchain and self-test path. It is the inverse of the processor's immediate generator: it takes a base instruction word, a 32-bit signed immediate and an immediate type, and packs the immediate into the I/S/J/B bit positions. It range-checks the immediate and flags unrepresentable values. Results pass through a 2-entry output queue with valid/ready handshakes on both sides, so the unit can sit between a test-program generator and an instruction memory writer.

## Interface
- No parameters.
- clk  in  1  clock; all state updates on rising edge
- reset  in  1  asynchronous, active-high; clears all state immediately
- in_val  in  1  request valid
- in_rdy  out  1  unit can accept a request this cycle
- in_base  in  32  instruction word; its immediate-field bits are ignored and overwritten
- in_imm  in  32  signed immediate (byte offset for J/B)
- in_imm_type  in  2  0=I, 1=S, 2=J, 3=B (same encoding as the immediate generator)
- out_val  out  1  result valid
- out_rdy  in  1  consumer accepts result
- out_inst  out  32  encoded instruction
- out_err  out  1  immediate was not representable for its type
- err_count  out  8  saturating count of errored requests accepted since reset

## Operation
- A request is accepted when in_val && in_rdy at a rising edge. A result is consumed when out_val && out_rdy.
- Field clear masks applied to in_base before insertion:
  - I: [31:20]
  - S: [31:25], [11:7]
  - J: [31:12]
  - B: [31:25], [11:7]
- Insertion:
  - I: [31:20]=imm[11:0]
  - S: [31:25]=imm[11:5], [11:7]=imm[4:0]
  - J: [31]=imm[20], [30:21]=imm[10:1], [20]=imm[11], [19:12]=imm[19:12]
  - B: [31]=imm[12], [30:25]=imm[10:5], [11:8]=imm[4:1], [7]=imm[11]
- Range rules (err=1 if violated):
  - I/S: imm[31:11] all equal.
  - J: imm[31:20] all equal and imm[0]==0.
  - B: imm[31:12] all equal and imm[0]==0.
- On error: out_inst = in_base with that type's immediate fields cleared to zero, out_err=1. err_count increments by 1 on acceptance and saturates at 255.
- Encoding is combinational on the inputs. The encoded word and err are written into a 2-entry FIFO (circular, 1-bit read/write pointers, 2-bit count).
- in_rdy = (count != 2). It is a function of registered state only and never depends on out_rdy (no bypass when full).
- out_val = (count != 0). out_inst and out_err show the FIFO head.
- Simultaneous enqueue and dequeue:
  - count 1: count stays 1, head advances, new entry is written.
  - count 2: enqueue is impossible because in_rdy=0. The dequeue proceeds and count goes to 1.
- out_inst and out_err hold stable while out_val && !out_rdy.

## Timing
- Reset values: count=0, pointers=0, out_val=0, in_rdy=1, err_count=0. out_inst and out_err read the entry-0 storage, which reset clears to 0.
- Latency: a request accepted at edge N appears at out_val/out_inst after edge N (visible cycle N+1). There is no combinational path from input to output.
- Throughput: 1 request per cycle when the consumer holds out_rdy=1.
- With out_rdy=0, exactly 2 requests are accepted, then in_rdy drops to 0 on the following cycle.
- Reset asserted mid-operation discards all queued entries. After reset deasserts, the first edge behaves as from empty.
- in_imm_type is sampled only on the accepting edge, so changes on other cycles have no effect.

## Test plan
- Basic encodes, out_rdy=1:
  - I: base 0x00000013, imm 5 -> 0x00500013, err 0.
  - S: base 0x00002023, imm 0xFFFFFFFC -> 0xFE002E23.
  - J: base 0x0000006F, imm 0x00000800 -> 0x0010006F.
  - B: base 0x00000063, imm 0xFFFFF000 -> 0x80000063.
  - Each result appears one cycle after acceptance.
- Field clearing: I with base 0xFFFFFFFF, imm 0 -> 0x000FFFFF. B with base 0xFFFFFFFF, imm 0 -> 0x01FFF07F.
- Errors: I imm 0x00000800 -> out_inst 0x00000013, err 1. B imm 3 -> err 1. J imm 0x00100000 -> err 1. After these three, err_count=3.
- Backpressure: hold out_rdy=0 and drive 3 back-to-back requests. Two are accepted and in_rdy=0 from the next cycle. Raise out_rdy: results drain in order, the third request is accepted, and no output changes while stalled.
- Simultaneous enqueue/dequeue at count 1 keeps count 1 over 10 cycles with in-order results. Saturation: 300 errored requests leave err_count=255.
- Assert reset with 2 entries queued: out_val=0, in_rdy=1 and err_count=0 immediately, without waiting for a clock edge.
